// File: rtl/gpa_fhdo_pkg.sv
// Shared definitions for the GPA-FHDO SPI responder.
// Holds the 24-bit frame field positions, the channel count, the bit
// counter width and the receive FSM state encoding.
package gpa_fhdo_pkg;

    localparam int FRAME_BITS = 24;
    localparam int WR_BIT     = 19;
    localparam int CH_MSB     = 18;
    localparam int CH_LSB     = 16;
    localparam int PAYLOAD_W  = 16;
    localparam int NUM_CH     = 4;

    // Bit counter saturates rather than wrapping, so overlong frames can
    // never alias back to a legal length.
    localparam int           CNT_W   = 6;
    localparam logic [5:0]   CNT_MAX = 6'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/gpa_fhdo_sync_edge.sv
// Input synchroniser with edge detection.
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flops, then compares the synchronised level with its previous sample.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (all flops clear to 0)
//   i_async  in   raw pin
//   o_level  out  synchronised level
//   o_rise   out  one-cycle pulse on a 0->1 transition of o_level
//   o_fall   out  one-cycle pulse on a 1->0 transition of o_level
module gpa_fhdo_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Clearing to 0 matters for csn: if csn is already low when reset is
    // released, no falling edge is seen and the FSM stays in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/gpa_fhdo_spi_rx.sv
// SPI responder emulating the GPA-FHDO 4-channel DAC.
// Deserialises 24-bit frames (MSB first, sampled on the sclk falling edge),
// decodes {ignored[23:20], write[19], channel[18:16], payload[15:0]} and
// holds the last value written to each channel. Frames with bit19=0 are
// passed out raw on cmd_o.
// Optional build macro: GPA_FHDO_SPI_RX_READBACK_EN
//   defined   : fhd_sdi_o shifts out {8'h00, chK} (K = last written channel)
//               MSB first, one bit per sclk rising edge.
//   undefined : fhd_sdi_o is tied low.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   fhd_clk_i/sdo_i/csn_i SPI clock, data (master out), chip select (low)
//   fhd_sdi_o             readback data to the master
//   ch0_o..ch3_o          channel registers
//   upd_o, upd_ch_o       one-cycle update pulse and its channel
//   cmd_o, cmd_valid_o    last non-DAC frame and its pulse
//   frame_err_o           sticky error, cleared by the next good frame
module gpa_fhdo_spi_rx
    import gpa_fhdo_pkg::*;
#(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fhd_clk_i,
    input  logic                  fhd_sdo_i,
    input  logic                  fhd_csn_i,
    output logic                  fhd_sdi_o,
    output logic [PAYLOAD_W-1:0]  ch0_o,
    output logic [PAYLOAD_W-1:0]  ch1_o,
    output logic [PAYLOAD_W-1:0]  ch2_o,
    output logic [PAYLOAD_W-1:0]  ch3_o,
    output logic                  upd_o,
    output logic [1:0]            upd_ch_o,
    output logic [23:0]           cmd_o,
    output logic                  cmd_valid_o,
    output logic                  frame_err_o
);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_sdo_lvl,  w_sdo_rise,  w_sdo_fall;
    logic w_csn_lvl,  w_csn_rise,  w_csn_fall;

    gpa_fhdo_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(fhd_clk_i),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    gpa_fhdo_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdo (
        .clk(clk), .rst_n(rst_n), .i_async(fhd_sdo_i),
        .o_level(w_sdo_lvl), .o_rise(w_sdo_rise), .o_fall(w_sdo_fall)
    );

    gpa_fhdo_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
        .clk(clk), .rst_n(rst_n), .i_async(fhd_csn_i),
        .o_level(w_csn_lvl), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
    );

    state_t                 r_state;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pend;
    logic [PAYLOAD_W-1:0]   r_ch [NUM_CH];
    logic                   r_upd;
    logic [1:0]             r_upd_ch;
    logic [23:0]            r_cmd;
    logic                   r_cmd_valid;
    logic                   r_err;

    logic       w_start;
    logic [2:0] w_frame_ch;
    logic       w_ch_ok;
    logic       w_unused;

    // A csn fall seen during CHECK is parked in r_pend so back-to-back
    // frames start one cycle later from IDLE instead of being lost.
    assign w_start    = (r_state == IDLE) && (w_csn_fall || r_pend);
    assign w_frame_ch = r_shift[CH_MSB:CH_LSB];
    assign w_ch_ok    = int'(w_frame_ch) < NUM_CH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_ch[i] <= '0;
            r_upd       <= 1'b0;
            r_upd_ch    <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_upd       <= 1'b0;
            r_cmd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pend <= 1'b0;
                    if (w_start) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                SHIFT: begin
                    // Shift before closing so a bit that coincides with the
                    // csn rise still belongs to this frame.
                    if (w_sclk_fall) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_sdo_lvl};
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_csn_rise) r_state <= CHECK;
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_pend  <= w_csn_fall;
                    if (r_cnt != 6'(FRAME_BITS)) begin
                        r_err <= 1'b1;
                    end else if (r_shift[WR_BIT]) begin
                        if (w_ch_ok) begin
                            r_ch[w_frame_ch[1:0]] <= r_shift[PAYLOAD_W-1:0];
                            r_upd    <= 1'b1;
                            r_upd_ch <= w_frame_ch[1:0];
                            r_err    <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cmd       <= r_shift[23:0];
                        r_cmd_valid <= 1'b1;
                        r_err       <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ch0_o       = r_ch[0];
    assign ch1_o       = r_ch[1];
    assign ch2_o       = r_ch[2];
    assign ch3_o       = r_ch[3];
    assign upd_o       = r_upd;
    assign upd_ch_o    = r_upd_ch;
    assign cmd_o       = r_cmd;
    assign cmd_valid_o = r_cmd_valid;
    assign frame_err_o = r_err;

`ifdef GPA_FHDO_SPI_RX_READBACK_EN
    logic [FRAME_BITS-1:0] r_tx;
    logic                  r_sdi;

    // r_upd_ch only changes on a valid write, so it already names the
    // channel of the previous valid write (0 after reset). Each sclk rise
    // presents the current MSB, so bit 23 is on the line for the first
    // falling (sampling) edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx  <= '0;
            r_sdi <= 1'b0;
        end else if (w_start) begin
            r_tx  <= {8'h00, r_ch[r_upd_ch]};
            r_sdi <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_sclk_rise) begin
                r_sdi <= r_tx[FRAME_BITS-1];
                r_tx  <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
        end else begin
            r_sdi <= 1'b0;
        end
    end

    assign fhd_sdi_o = r_sdi;
    assign w_unused  = ^{w_csn_lvl, w_sdo_rise, w_sdo_fall, w_sclk_lvl};
`else
    assign fhd_sdi_o = 1'b0;
    assign w_unused  = ^{w_csn_lvl, w_sdo_rise, w_sdo_fall, w_sclk_lvl, w_sclk_rise};
`endif

endmodule
